// File: rtl/display_scan_n.sv
// -----------------------------------------------------------------------------
// display_scan_n
//
// Multiplexed 7-segment scan driver for DIGITS common-anode digits. Each digit
// owns one slot of DIV clock cycles. The leftmost digit (index DIGITS-1) is
// scanned first. The driver includes a hex decoder, per-digit decimal points,
// leading-zero suppression, a per-digit blink mask, PWM brightness and a
// one-cycle frame-complete strobe.
//
// Parameters
//   DIGITS        number of digits scanned (2..8)
//   DIV           clock cycles per digit slot, a multiple of 2**BRIGHT_W
//   BRIGHT_W      brightness control width
//   BLINK_FRAMES  complete scan frames per blink half-period (>= 1)
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   digits_i      hex nibbles; digit 0 (rightmost) in bits [3:0]
//   dp_i          decimal point request per digit
//   lz_en_i       leading-zero suppression enable
//   blink_mask_i  digits to blink
//   brightness_i  duty level; 0 = 1/2**BRIGHT_W on-time, all ones = 100 %
//   led7_an_o     anodes, active-low, bit i = digit i
//   led7_seg_o    segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_o       one-cycle pulse after the last digit of each scan
// -----------------------------------------------------------------------------
module display_scan_n #(
  parameter int DIGITS       = 4,
  parameter int DIV          = 10000,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4*DIGITS-1:0]   digits_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  lz_en_i,
  input  logic [DIGITS-1:0]     blink_mask_i,
  input  logic [BRIGHT_W-1:0]   brightness_i,
  output logic [DIGITS-1:0]     led7_an_o,
  output logic [7:0]            led7_seg_o,
  output logic                  frame_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // On-time granted per brightness step.
  localparam int SLICE = DIV >> BRIGHT_W;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [FC_W-1:0]  LAST_FC  = FC_W'(BLINK_FRAMES - 1);

  // Standard hex glyphs, active-high, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] glyph;
    glyph = 7'h00;
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
    return glyph;
  endfunction

  // Scan state
  logic [CNT_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic                scan_live;  // low during the dark slot right after reset
  logic                slot_end;
  logic [IDX_W-1:0]    idx_nxt;

  // Per-slot snapshot of the inputs for the digit being shown
  logic [3:0]          snap_nib;
  logic                snap_dp;
  logic                snap_sup;
  logic                snap_blink;
  logic [BRIGHT_W-1:0] snap_bright;

  // Live selection feeding the snapshot
  logic [DIGITS-1:0]   sup;
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_sup;
  logic                sel_blink;

  // Blink machinery
  logic [FC_W-1:0]     frame_cnt;
  logic                blink_phase;

  // Output next-values
  logic [DIGITS-1:0]   an_d;
  logic [7:0]          seg_d;
  logic                blank;
  logic [31:0]         thr;

  assign slot_end = (presc == LAST_CNT);

  // After reset, idx already holds DIGITS-1. The first boundary only arms the
  // scan, so that digit becomes the first lit slot. Later boundaries step
  // the index downward and wrap from 0 back to DIGITS-1.
  assign idx_nxt = (!scan_live || idx == '0) ? LAST_IDX : idx - IDX_W'(1);

  // A digit is suppressed while it and everything to its left are zero
  // with no decimal point requested. The run is built from the left end.
  // Digit 0 is never suppressed.
  always_comb begin
    logic zero_run;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    sup      = '0;
    zero_run = lz_en_i;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (digits_i[4*i +: 4] == 4'h0) & ~dp_i[i];
      sup[i]   = zero_run;
    end
  end

  // Mux the inputs of the digit that the coming slot will show.
  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_sup   = 1'b0;
    sel_blink = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        sel_nib   = digits_i[4*i +: 4];
        sel_dp    = dp_i[i];
        sel_sup   = sup[i];
        sel_blink = blink_mask_i[i];
      end
    end
  end

  // Prescaler, index and snapshot. Inputs are sampled only at slot
  // boundaries, so changes in mid-slot wait for the next digit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc       <= '0;
      idx         <= LAST_IDX;
      scan_live   <= 1'b0;
      snap_nib    <= 4'h0;
      snap_dp     <= 1'b0;
      snap_sup    <= 1'b0;
      snap_blink  <= 1'b0;
      snap_bright <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments. Every register then samples pre-edge values.
      presc <= slot_end ? '0 : presc + CNT_W'(1);
      if (slot_end) begin
        idx         <= idx_nxt;
        scan_live   <= 1'b1;
        snap_nib    <= sel_nib;
        snap_dp     <= sel_dp;
        snap_sup    <= sel_sup;
        snap_blink  <= sel_blink;
        snap_bright <= brightness_i;
      end
    end
  end

  // Count complete frames. Toggle the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_o) begin
      if (frame_cnt == LAST_FC) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  // Output decode. This registers the state of prescaler value p, so the
  // pins show it one cycle later. The anode is on for the first thr
  // prescaler values of the slot. Segments hold the glyph for the whole slot.
  always_comb begin
    thr   = (32'(snap_bright) + 32'd1) * 32'(SLICE);
    blank = !scan_live || snap_sup || (snap_blink && blink_phase);
    an_d  = '1;
    seg_d = 8'hFF;
    if (!blank) begin
      seg_d = {~snap_dp, ~hex_glyph(snap_nib)};
      if (32'(presc) < thr) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx == IDX_W'(i)) an_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led7_an_o  <= '1;
      led7_seg_o <= 8'hFF;
      frame_o    <= 1'b0;
    end else begin
      led7_an_o  <= an_d;
      led7_seg_o <= seg_d;
      // The boundary that wraps index 0 back to DIGITS-1 closes a frame.
      frame_o    <= slot_end && scan_live && (idx == '0);
    end
  end

endmodule

// File: tb/tb_display_scan_n.sv
// -----------------------------------------------------------------------------
// tb_display_scan_n
//
// Directed bench for display_scan_n. It runs a 4-digit instance (DIV=8,
// BLINK_FRAMES=2) and a 6-digit instance (DIV=8). Outputs are sampled on the
// falling clock edge. One slot equals DIV samples.
// -----------------------------------------------------------------------------
module tb_display_scan_n;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits4;
  logic [3:0]  dp4;
  logic [3:0]  mask4;
  logic [23:0] digits6;
  logic [5:0]  dp6;
  logic [5:0]  mask6;
  logic        lz_en;
  logic [2:0]  bright;

  logic [3:0]  an4;
  logic [7:0]  seg4;
  logic        frame4;
  logic [5:0]  an6;
  logic [7:0]  seg6;
  logic        frame6;

  int n_vec  = 0;
  int n_fail = 0;

  // Negedge count since reset release and the counts at which frame_o was high.
  int cyc = 0;
  int fq4[$];
  int fq6[$];

  always #5 clk = ~clk;

  display_scan_n #(.DIGITS(4), .DIV(DIV), .BRIGHT_W(3), .BLINK_FRAMES(2)) dut4 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .digits_i     (digits4),
    .dp_i         (dp4),
    .lz_en_i      (lz_en),
    .blink_mask_i (mask4),
    .brightness_i (bright),
    .led7_an_o    (an4),
    .led7_seg_o   (seg4),
    .frame_o      (frame4)
  );

  display_scan_n #(.DIGITS(6), .DIV(DIV), .BRIGHT_W(3), .BLINK_FRAMES(64)) dut6 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .digits_i     (digits6),
    .dp_i         (dp6),
    .lz_en_i      (lz_en),
    .blink_mask_i (mask6),
    .brightness_i (bright),
    .led7_an_o    (an6),
    .led7_seg_o   (seg6),
    .frame_o      (frame6)
  );

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      fq4.delete();
      fq6.delete();
    end else begin
      cyc = cyc + 1;
      if (frame4) fq4.push_back(cyc);
      if (frame6) fq6.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe one slot of DIV samples. The digit must be on for exactly the
  // first on_exp samples and fully dark otherwise. Segments must hold one
  // value. At sample chg_at, brightness becomes chg_bri (-1 leaves it as is).
  task automatic check_slot(input string tag, input int which, input int idx,
                            input logic [7:0] seg_exp, input int on_exp,
                            input int chg_at, input logic [2:0] chg_bri);
    logic [7:0] an_exp;
    logic [7:0] an_obs;
    logic [7:0] seg_obs;
    logic [7:0] seg_first;
    int on;
    int bad;
    an_exp    = 8'hFF & ~(8'd1 << idx);
    on        = 0;
    bad       = 0;
    seg_first = 8'h00;
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      an_obs  = (which == 4) ? {4'hF, an4} : {2'b11, an6};
      seg_obs = (which == 4) ? seg4 : seg6;
      if (i == 0) seg_first = seg_obs;
      else if (seg_obs !== seg_first) bad++;
      if (an_obs === an_exp) begin
        if (i != on) bad++;
        on++;
      end else if (an_obs !== 8'hFF) begin
        bad++;
      end
      if (i == chg_at) bright = chg_bri;
    end
    check({tag, ":seg"}, 32'(seg_first), 32'(seg_exp));
    check({tag, ":on"}, on, on_exp);
    check({tag, ":glitch"}, bad, 0);
  endtask

  task automatic scan4(input string tag,
                       input logic [7:0] s3, input logic [7:0] s2,
                       input logic [7:0] s1, input logic [7:0] s0,
                       input int o3, input int o2, input int o1, input int o0);
    check_slot({tag, "_d3"}, 4, 3, s3, o3, -1, 3'd0);
    check_slot({tag, "_d2"}, 4, 2, s2, o2, -1, 3'd0);
    check_slot({tag, "_d1"}, 4, 1, s1, o1, -1, 3'd0);
    check_slot({tag, "_d0"}, 4, 0, s0, o0, -1, 3'd0);
  endtask

  task automatic skip_slots(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    digits4 = 16'h12AF;
    dp4     = 4'b0000;
    mask4   = 4'b0000;
    digits6 = 24'h123456;
    dp6     = 6'b000100;
    mask6   = 6'b000000;
    lz_en   = 1'b0;
    bright  = 3'd7;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an4), 32'hF);
    check("rst_seg", 32'(seg4), 32'hFF);
    check("rst_frame", 32'(frame4), 32'h0);
    #2 rst_n = 1'b1;

    // 1: the first slot is dark. Then digits 3..0 show 1, 2, A, F at full duty.
    repeat (DIV) @(negedge clk);
    check("t1_dark_an", 32'(an4), 32'hF);
    check("t1_dark_seg", 32'(seg4), 32'hFF);
    check("t1_dark_frame", 32'(frame4), 32'h0);
    scan4("t1a", 8'hF9, 8'hA4, 8'h88, 8'h8E, 8, 8, 8, 8);
    scan4("t1b", 8'hF9, 8'hA4, 8'h88, 8'h8E, 8, 8, 8, 8);
    #1;
    check("t1_frame_cnt", fq4.size(), 2);
    check("t1_frame_first", (fq4.size() > 0) ? fq4[0] : -1, 40);
    check("t1_frame_period", (fq4.size() > 1) ? fq4[1] - fq4[0] : -1, 32);

    // 2: leading-zero suppression. A decimal point stops suppression.
    lz_en   = 1'b1;
    digits4 = 16'h0042;
    skip_slots(4);
    scan4("t2a", 8'hFF, 8'hFF, 8'h99, 8'hA4, 0, 0, 8, 8);
    dp4 = 4'b0100;
    skip_slots(4);
    scan4("t2b", 8'hFF, 8'h40, 8'h99, 8'hA4, 0, 8, 8, 8);

    // 3: all zero. Only digit 0 stays lit.
    digits4 = 16'h0000;
    dp4     = 4'b0000;
    skip_slots(4);
    scan4("t3", 8'hFF, 8'hFF, 8'hFF, 8'hC0, 0, 0, 0, 8);

    // 4: PWM duty. A brightness change in mid-slot applies from the next slot.
    digits4 = 16'h12AF;
    lz_en   = 1'b0;
    bright  = 3'd0;
    skip_slots(4);
    scan4("t4a", 8'hF9, 8'hA4, 8'h88, 8'h8E, 1, 1, 1, 1);
    bright = 3'd3;
    skip_slots(4);
    scan4("t4b", 8'hF9, 8'hA4, 8'h88, 8'h8E, 4, 4, 4, 4);
    check_slot("t4c_d3", 4, 3, 8'hF9, 4, 2, 3'd0);
    check_slot("t4c_d2", 4, 2, 8'hA4, 1, -1, 3'd0);
    check_slot("t4c_d1", 4, 1, 8'h88, 1, -1, 3'd0);
    check_slot("t4c_d0", 4, 0, 8'h8E, 1, -1, 3'd0);

    // 6: asynchronous reset in mid-slot, then a 6-digit scan from reset.
    bright = 3'd7;
    @(negedge clk);
    check("t6_pre_an", 32'(an4), 32'h7);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_an4", 32'(an4), 32'hF);
    check("t6_rst_seg4", 32'(seg4), 32'hFF);
    check("t6_rst_frame4", 32'(frame4), 32'h0);
    check("t6_rst_an6", 32'(an6), 32'h3F);
    check("t6_rst_seg6", 32'(seg6), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (DIV) @(negedge clk);
    check("t6_dark_an6", 32'(an6), 32'h3F);
    check("t6_dark_seg6", 32'(seg6), 32'hFF);
    check_slot("t6_d5", 6, 5, 8'hF9, 8, -1, 3'd0);
    check_slot("t6_d4", 6, 4, 8'hA4, 8, -1, 3'd0);
    check_slot("t6_d3", 6, 3, 8'hB0, 8, -1, 3'd0);
    check_slot("t6_d2", 6, 2, 8'h19, 8, -1, 3'd0);
    check_slot("t6_d1", 6, 1, 8'h92, 8, -1, 3'd0);
    check_slot("t6_d0", 6, 0, 8'h82, 8, -1, 3'd0);
    #1;
    check("t6_frame_cnt", fq6.size(), 1);
    check("t6_frame_first", (fq6.size() > 0) ? fq6[0] : -1, 56);

    // 5: blink digit 0. It is lit for frames 1-2, dark for 3-4, lit again for 5.
    mask4 = 4'b0001;
    @(negedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (DIV) @(negedge clk);
    check("t5_dark_an", 32'(an4), 32'hF);
    for (int s = 1; s <= 5; s++) begin
      scan4($sformatf("t5_s%0d", s), 8'hF9, 8'hA4, 8'h88,
            (s == 3 || s == 4) ? 8'hFF : 8'h8E,
            8, 8, 8, (s == 3 || s == 4) ? 0 : 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
